// File: rtl/occ_pattern_pkg.sv
// occ_pattern_pkg
// Shared definitions for the OCC link-test pattern: the comma word that
// frames each pattern period, the K-flag encodings for comma and data words,
// and the receive checker state type. Intended to be shared with a future
// TX pattern generator so both ends agree on the framing.
`timescale 1ns/1ps
package occ_pattern_pkg;

  // Comma word: K28.5 in the upper byte, D21.4 in the lower byte.
  localparam logic [15:0] c_COMMA_DATA = 16'hBC95;
  localparam logic [1:0]  c_COMMA_K    = 2'b10;
  localparam logic [1:0]  c_DATA_K     = 2'b00;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_SYNC     = 2'd1,
    ST_LOCKED   = 2'd2
  } t_chk_state;

endpackage

// File: rtl/occ_sat_counter.sv
// occ_sat_counter
// Statistics counter that sticks at all-ones instead of wrapping, so a long
// BER run never reports a misleadingly small count. A synchronous clear
// takes priority over an increment in the same cycle.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset (count -> 0)
//   clr_i  synchronous clear
//   inc_i  increment request
//   cnt_o  current count
`timescale 1ns/1ps
module occ_sat_counter #(
  parameter int g_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [g_WIDTH-1:0] cnt_o
);

  // Count up on request, hold once every bit is set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + g_WIDTH'(1);
    end
  end

endmodule

// File: rtl/occ_rx_pattern_checker.sv
// occ_rx_pattern_checker
// Receive-side checker for the OCC link-test pattern. Locks onto the
// comma-framed incrementing-counter stream coming out of the transceiver
// and checks every following word, keeping saturating statistics.
// Ports:
//   clk_i            transceiver user clock
//   rst_i            asynchronous active-high reset
//   en_i             checker enable; low forces UNLOCKED, counters hold
//   clr_i            synchronous clear of all counters
//   rxdata_i         received 16-bit word
//   rxcharisk_i      K flags, bit 1 = upper byte
//   rxdisperr_i      disparity error per byte
//   rxnotintable_i   not-in-table per byte
//   rxbyterealign_i  comma realignment event
//   locked_o         pattern lock
//   err_p_o          one-cycle pulse per mismatched word while locked
//   word_cnt_o       words checked while locked
//   err_cnt_o        mismatched words while locked
//   code_err_cnt_o   words with any 8b/10b code error while enabled
`timescale 1ns/1ps
module occ_rx_pattern_checker
  import occ_pattern_pkg::*;
#(
  parameter int g_CNT_WIDTH         = 32,
  parameter int g_UNLOCK_ERRS       = 4,
  parameter int g_COMMA_PERIOD_LOG2 = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [15:0]            rxdata_i,
  input  logic [1:0]             rxcharisk_i,
  input  logic [1:0]             rxdisperr_i,
  input  logic [1:0]             rxnotintable_i,
  input  logic                   rxbyterealign_i,
  output logic                   locked_o,
  output logic                   err_p_o,
  output logic [g_CNT_WIDTH-1:0] word_cnt_o,
  output logic [g_CNT_WIDTH-1:0] err_cnt_o,
  output logic [g_CNT_WIDTH-1:0] code_err_cnt_o
);

  localparam int c_N        = g_COMMA_PERIOD_LOG2;
  localparam int c_CONSEC_W = $clog2(g_UNLOCK_ERRS + 1);

  t_chk_state            state;
  logic [15:0]           exp_idx;
  logic [c_CONSEC_W-1:0] consec;

  logic        en_q;
  logic        clr_q;
  logic [15:0] data_q;
  logic [1:0]  k_q;
  logic        code_err_q;
  logic        realign_q;

  logic is_comma;
  logic is_data;
  logic slot_is_comma;
  logic word_match;
  logic sync_ok;
  logic compare_en;
  logic mismatch;
  logic unlock_now;

  // Every input is registered first, so a word presented at one edge shows
  // its effect on the outputs at the following edge. The clear and enable
  // travel with the word so a clear lines up with the word it accompanies.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q       <= 1'b0;
      clr_q      <= 1'b0;
      data_q     <= '0;
      k_q        <= '0;
      code_err_q <= 1'b0;
      realign_q  <= 1'b0;
    end else begin
      en_q       <= en_i;
      clr_q      <= clr_i;
      data_q     <= rxdata_i;
      k_q        <= rxcharisk_i;
      code_err_q <= |{rxdisperr_i, rxnotintable_i};
      realign_q  <= rxbyterealign_i;
    end
  end

  // Classify the registered word and compare it against the expected slot.
  // A slot whose low index bits are zero must carry the comma; every other
  // slot must carry the index itself as a data word.
  always_comb begin
    is_comma      = (k_q == c_COMMA_K) && (data_q == c_COMMA_DATA);
    is_data       = (k_q == c_DATA_K);
    slot_is_comma = (exp_idx[c_N-1:0] == '0);
    word_match    = slot_is_comma ? is_comma : (is_data && (data_q == exp_idx));
    sync_ok       = is_data && (data_q[c_N-1:0] == c_N'(1));
    compare_en    = en_q && (state == ST_LOCKED) && !realign_q;
    mismatch      = compare_en && !word_match;
    unlock_now    = mismatch && (consec == c_CONSEC_W'(g_UNLOCK_ERRS - 1));
  end

  // Lock state machine. In LOCKED the expected index advances on every word
  // whether or not it matched, so one corrupted word costs a single error
  // instead of knocking the checker out of step with the stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_UNLOCKED;
      exp_idx <= '0;
      consec  <= '0;
      err_p_o <= 1'b0;
    end else begin
      err_p_o <= mismatch;
      if (!en_q) begin
        state  <= ST_UNLOCKED;
        consec <= '0;
      end else begin
        case (state)
          ST_UNLOCKED: begin
            consec <= '0;
            if (is_comma) begin
              state <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (realign_q) begin
              state <= ST_UNLOCKED;
            end else if (sync_ok) begin
              state   <= ST_LOCKED;
              exp_idx <= data_q + 16'd1;
              consec  <= '0;
            end else if (!is_comma) begin
              state <= ST_UNLOCKED;
            end
          end
          ST_LOCKED: begin
            if (realign_q) begin
              state  <= ST_UNLOCKED;
              consec <= '0;
            end else begin
              exp_idx <= exp_idx + 16'd1;
              if (word_match) begin
                consec <= '0;
              end else if (unlock_now) begin
                state  <= ST_UNLOCKED;
                consec <= '0;
              end else begin
                consec <= consec + c_CONSEC_W'(1);
              end
            end
          end
          default: begin
            state <= ST_UNLOCKED;
          end
        endcase
      end
    end
  end

  assign locked_o = (state == ST_LOCKED);

  occ_sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_word_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_q),
    .inc_i (compare_en),
    .cnt_o (word_cnt_o)
  );

  occ_sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_q),
    .inc_i (mismatch),
    .cnt_o (err_cnt_o)
  );

  // Code errors are counted in any lock state as long as the checker is on.
  occ_sat_counter #(.g_WIDTH(g_CNT_WIDTH)) u_code_err_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr_q),
    .inc_i (en_q && code_err_q),
    .cnt_o (code_err_cnt_o)
  );

endmodule

// File: tb/tb_occ_rx_pattern_checker.sv
// tb_occ_rx_pattern_checker
// Directed bench for occ_rx_pattern_checker: clean lock-up, index wrap,
// isolated and consecutive corruption, code errors with realignment,
// counter clear, enable drop and asynchronous reset.
`timescale 1ns/1ps
module tb_occ_rx_pattern_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clr;
  logic [15:0] rxdata;
  logic [1:0]  rxcharisk;
  logic [1:0]  rxdisperr;
  logic [1:0]  rxnotintable;
  logic        rxbyterealign;
  logic        locked;
  logic        err_p;
  logic [31:0] word_cnt;
  logic [31:0] err_cnt;
  logic [31:0] code_err_cnt;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] idx;
  logic [31:0] w_hold;
  logic [31:0] c_hold;

  always #5 clk = ~clk;

  occ_rx_pattern_checker #(
    .g_CNT_WIDTH         (32),
    .g_UNLOCK_ERRS       (4),
    .g_COMMA_PERIOD_LOG2 (5)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .clr_i           (clr),
    .rxdata_i        (rxdata),
    .rxcharisk_i     (rxcharisk),
    .rxdisperr_i     (rxdisperr),
    .rxnotintable_i  (rxnotintable),
    .rxbyterealign_i (rxbyterealign),
    .locked_o        (locked),
    .err_p_o         (err_p),
    .word_cnt_o      (word_cnt),
    .err_cnt_o       (err_cnt),
    .code_err_cnt_o  (code_err_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one word, let the next rising edge sample it, return 1 ns later.
  task automatic applyStimulus(input logic [15:0] data, input logic [1:0] k,
                               input logic [1:0] disp, input logic realign,
                               input logic clear);
    rxdata        = data;
    rxcharisk     = k;
    rxdisperr     = disp;
    rxnotintable  = 2'b00;
    rxbyterealign = realign;
    clr           = clear;
    @(posedge clk);
    #1;
  endtask

  // Send the correct pattern word for the current index and advance.
  task automatic sendPattern(input logic [1:0] disp, input logic realign);
    if (idx[4:0] == 5'd0) applyStimulus(16'hBC95, 2'b10, disp, realign, 1'b0);
    else                  applyStimulus(idx, 2'b00, disp, realign, 1'b0);
    idx = idx + 16'd1;
  endtask

  // Send a wrong data word in the current slot and advance.
  task automatic sendCorrupt(input logic [15:0] data, input logic clear);
    applyStimulus(data, 2'b00, 2'b00, 1'b0, clear);
    idx = idx + 16'd1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0;
    rxdata = '0; rxcharisk = '0; rxdisperr = '0; rxnotintable = '0; rxbyterealign = 1'b0;
    idx = 16'h0000;
    #12;
    checkOutput("reset_locked", {31'd0, locked}, 32'd0);
    checkOutput("reset_err_p", {31'd0, err_p}, 32'd0);
    checkOutput("reset_word_cnt", word_cnt, 32'd0);
    checkOutput("reset_err_cnt", err_cnt, 32'd0);
    checkOutput("reset_code_err_cnt", code_err_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clean pattern from index 0: comma, data 1, data 2, ... up to 10000.
    $display("[TB] clean pattern");
    sendPattern(2'b00, 1'b0);
    sendPattern(2'b00, 1'b0);
    checkOutput("lock_not_yet", {31'd0, locked}, 32'd0);
    sendPattern(2'b00, 1'b0);
    checkOutput("lock_third_cycle", {31'd0, locked}, 32'd1);
    for (int j = 3; j <= 10000; j++) sendPattern(2'b00, 1'b0);
    checkOutput("clean_locked", {31'd0, locked}, 32'd1);
    checkOutput("clean_word_cnt", word_cnt, 32'd9998);
    checkOutput("clean_err_cnt", err_cnt, 32'd0);
    checkOutput("clean_code_err_cnt", code_err_cnt, 32'd0);

    // Asynchronous reset while locked clears every output at once.
    rst = 1'b1;
    #1;
    checkOutput("async_rst_locked", {31'd0, locked}, 32'd0);
    checkOutput("async_rst_word_cnt", word_cnt, 32'd0);
    checkOutput("async_rst_err_cnt", err_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Index wrap 0xFFE0 .. 0x0020.
    $display("[TB] wrap-around");
    idx = 16'hFFE0;
    for (int j = 0; j <= 64; j++) sendPattern(2'b00, 1'b0);
    checkOutput("wrap_locked", {31'd0, locked}, 32'd1);
    checkOutput("wrap_err_cnt", err_cnt, 32'd0);
    checkOutput("wrap_word_cnt", word_cnt, 32'd62);

    // Single corrupt word in slot 0x0045.
    $display("[TB] single corrupt word");
    while (idx != 16'h0045) sendPattern(2'b00, 1'b0);
    sendCorrupt(16'h1234, 1'b0);
    sendPattern(2'b00, 1'b0);
    checkOutput("single_err_p", {31'd0, err_p}, 32'd1);
    checkOutput("single_err_cnt", err_cnt, 32'd1);
    checkOutput("single_locked", {31'd0, locked}, 32'd1);
    sendPattern(2'b00, 1'b0);
    checkOutput("single_err_p_clears", {31'd0, err_p}, 32'd0);

    // Four consecutive corrupt words drop the lock one cycle after the last.
    $display("[TB] consecutive corruption");
    for (int j = 0; j < 4; j++) sendCorrupt(16'h0F0F, 1'b0);
    checkOutput("consec_still_locked", {31'd0, locked}, 32'd1);
    sendPattern(2'b00, 1'b0);
    checkOutput("consec_unlocked", {31'd0, locked}, 32'd0);
    checkOutput("consec_err_cnt", err_cnt, 32'd5);
    for (int j = 0; j < 40; j++) sendPattern(2'b00, 1'b0);
    checkOutput("consec_relocked", {31'd0, locked}, 32'd1);
    checkOutput("consec_err_cnt_hold", err_cnt, 32'd5);

    // Disparity error on one word, then a realignment pulse.
    $display("[TB] code error and realign");
    sendPattern(2'b01, 1'b0);
    w_hold = word_cnt;
    sendPattern(2'b00, 1'b1);
    sendPattern(2'b00, 1'b0);
    checkOutput("realign_unlocked", {31'd0, locked}, 32'd0);
    checkOutput("code_err_cnt_one", code_err_cnt, 32'd1);
    checkOutput("realign_word_not_counted", word_cnt, w_hold + 32'd1);
    for (int j = 0; j < 40; j++) sendPattern(2'b00, 1'b0);
    checkOutput("realign_relocked", {31'd0, locked}, 32'd1);
    checkOutput("realign_err_cnt_hold", err_cnt, 32'd5);

    // Clear arriving with a mismatched word wins over the increment.
    $display("[TB] clear with mismatch");
    sendCorrupt(16'h5555, 1'b1);
    sendPattern(2'b00, 1'b0);
    checkOutput("clr_err_p", {31'd0, err_p}, 32'd1);
    checkOutput("clr_err_cnt", err_cnt, 32'd0);
    checkOutput("clr_word_cnt", word_cnt, 32'd0);
    checkOutput("clr_code_err_cnt", code_err_cnt, 32'd0);
    sendPattern(2'b00, 1'b0);
    checkOutput("clr_word_cnt_resumes", word_cnt, 32'd1);
    checkOutput("clr_state_kept", {31'd0, locked}, 32'd1);

    // Enable low: unlock and hold counters, even with code errors present.
    $display("[TB] enable low");
    en = 1'b0;
    sendPattern(2'b11, 1'b0);
    w_hold = word_cnt;
    c_hold = code_err_cnt;
    sendPattern(2'b11, 1'b0);
    sendPattern(2'b11, 1'b0);
    checkOutput("en_low_unlocked", {31'd0, locked}, 32'd0);
    checkOutput("en_low_word_hold", word_cnt, w_hold);
    checkOutput("en_low_code_hold", code_err_cnt, c_hold);
    checkOutput("en_low_err_p", {31'd0, err_p}, 32'd0);
    en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
